shared_vfifo_1r1w: RTL and testbench
====================================

Name: shared_vfifo_1r1w

Overview:
- Bank of fifos_p independent virtual FIFOs, each els_p deep and width_p wide.
- All payload storage is one shared 1-read/1-write synchronous RAM.
- Each virtual FIFO has its own pointer tracker, a head register and a single-entry bypass register.
- Sits between a single shared producer (one enqueue per cycle, tagged by FIFO id) and per-FIFO consumers (valid/yumi handshake).

Parameters:
- width_p, none (required): payload width in bits, ≥1.
- els_p, none (required): depth of each virtual FIFO, ≥1; need not be a power of two.
- fifos_p, none (required): number of virtual FIFOs, ≥1; need not be a power of two.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  enqueue request.
- enq_id_i  in  max(1,clog2(fifos_p))  target FIFO of the enqueue.
- data_i  in  width_p  enqueue payload.
- ready_param_o  out  fifos_p  bit i = FIFO i not full.
- v_o  out  fifos_p  bit i = FIFO i not empty.
- data_o  out  fifos_p×width_p  head element of each FIFO.
- yumi_i  in  fifos_p  dequeue of FIFO i; at most one bit set per cycle.

Behaviour:
- Reset (asynchronous, active-low): all pointers, full/empty state, bypass flags and read-pending state clear.
  - After reset: v_o=0, ready_param_o=all ones, data_o=0 (head and bypass data registers reset to 0).
- Enqueue handshake:
  - enq one-hot = decode(enq_id_i) gated by v_i, ANDed with ready_param_o.
  - Enqueue to a full FIFO is dropped.
  - enq_id_i ≥ fifos_p decodes to no FIFO (dropped).
- Dequeue: yumi_i[i] is legal only when v_o[i]=1; the element is consumed on that clock edge.
- Per-FIFO tracker:
  - wptr/rptr count 0..els_p-1 and wrap to 0 after els_p-1.
  - rptr_n = rptr+1 (wrapped) when dequeuing, else rptr.
  - Occupancy is tracked so that full and empty are exact, including els_p=1.
- Address mapping: addr = i*els_p + ptr; RAM depth is fifos_p*els_p.
- Let same_i = enq_i & (wptr_i == rptr_n_i).
  - same_i=1: no RAM write or read for FIFO i. data_i is captured into the bypass register and the bypass flag is set.
  - Flag next value = set ? 1 : (deq ? 0 : hold). Set dominates clear.
- RAM write when enq_i & wptr_i≠rptr_n_i: writes data_i at FIFO i's wptr address.
- RAM read when yumi_i[i] & wptr_i≠rptr_n_i:
  - Reads FIFO i's rptr_n address.
  - The read id and a read-valid flag are registered.
  - The next cycle, the RAM output passes combinationally to head_i and is latched into head_i (enable-with-bypass register).
- data_o[i] = bypass_flag_i ? bypass_i : head_i.
- Whenever v_o[i]=1, data_o[i] is the oldest element.
- Latency:
  - Enqueue→v_o: 1 cycle.
  - After a dequeue with ≥2 elements, the next head is on data_o the following cycle, with no bubble.
- Full throughput: simultaneous enqueue and dequeue on the same FIFO or on different FIFOs each cycle. Occupancy is unchanged on a same-FIFO enq+deq.
- RAM never sees a same-address read and write in one cycle: same-FIFO collisions go to bypass, and different FIFOs use disjoint address ranges.
- Reset asserted mid-operation: all FIFOs empty immediately; RAM contents are don't-care.

Optional Feature:
- SHARED_VFIFO_CHECKS_EN: when defined, simulation-only checks print an error on each of:
  - enqueue to a full FIFO;
  - enq_id_i out of range while v_i=1;
  - yumi_i on an empty FIFO;
  - yumi_i not onehot0;
  - a same-address RAM read and write in one cycle.
- When undefined: no checks; the logic is identical.

Decomposition:
- Package shared_vfifo_pkg: address-width and pointer-width helper functions, e.g. safe clog2 returning ≥1.
- One sub-module, shared_vfifo_tracker: per-FIFO wptr/rptr/rptr_n, full/empty.
- The RAM is an inline register array with registered read.

Test Plan:
- Reset, then enqueue 0xA5 to FIFO 0 (width 8, els 4, fifos 3) -> next cycle v_o=3'b001, data_o[0]=0xA5; all ready bits stay 1.
- Enqueue 0x01..0x04 into FIFO 1 -> ready_param_o[1]=0 after the 4th. A 5th enqueue is dropped. Four yumis, one per cycle, return 0x01,0x02,0x03,0x04 back-to-back, then v_o[1]=0.
- FIFO 2 holds one element 0x10; enqueue 0x11 and yumi FIFO 2 in the same cycle -> next cycle v_o[2]=1, data_o[2]=0x11, bypass path used.
- Interleave: enqueue FIFO 0 while dequeuing FIFO 1, both pointers equal -> both data streams stay correct; no RAM address collision.
- els_p=1, fifos_p=2: enqueue 0x7 to FIFO 1 -> ready_param_o[1]=0; yumi -> empty; the RAM is never accessed.
- Assert reset_n_i low mid-stream with FIFOs partially full -> v_o=0, ready_param_o=all ones immediately, without waiting for a clock.

Source files
------------

// File: rtl/shared_vfifo_pkg.sv
// Shared helpers for the shared_vfifo_1r1w virtual-FIFO bank.
//   safe_clog2  : ceil(log2(n)) clamped to at least 1, so 1-entry or
//                 1-FIFO configurations still get a legal 1-bit field.
//   addr_width  : address width of the shared RAM (fifos * els entries).
package shared_vfifo_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_width(input int fifos, input int els);
    return safe_clog2(fifos * els);
  endfunction

endpackage

// File: rtl/shared_vfifo_tracker.sv
// Pointer/occupancy tracker for one virtual FIFO.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   enq, deq         : accepted enqueue / dequeue this cycle
//   wptr             : slot the next enqueue lands in
//   rptr_n           : read pointer after this cycle's dequeue
//   full, empty      : exact occupancy flags (count based, so els_p=1 works)
module shared_vfifo_tracker
  import shared_vfifo_pkg::*;
#(
  parameter int els_p = 4,
  localparam int ptr_w_lp = safe_clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enq,
  input  logic                deq,
  output logic [ptr_w_lp-1:0] wptr,
  output logic [ptr_w_lp-1:0] rptr_n,
  output logic                full,
  output logic                empty
);

  localparam int cnt_w_lp = safe_clog2(els_p + 1);

  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign wptr   = wptr_r;
  assign rptr_n = deq ? ptr_inc(rptr_r) : rptr_r;
  assign full   = (count_r == cnt_w_lp'(els_p));
  assign empty  = (count_r == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      rptr_r <= rptr_n;
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/shared_vfifo_1r1w.sv
// Bank of fifos_p virtual FIFOs (els_p deep, width_p wide) sharing one
// 1R1W register-array RAM with registered read. Each FIFO has a head
// register fed by the RAM and a one-entry bypass register used when the
// enqueued element becomes the head immediately, so the RAM never sees a
// same-address read and write.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, enq_id_i, data_i : shared producer enqueue (out-of-range id dropped)
//   ready_param_o    : per-FIFO not full
//   v_o, data_o      : per-FIFO not empty and head element
//   yumi_i           : per-FIFO dequeue, at most one bit per cycle
// Optional macro SHARED_VFIFO_CHECKS_EN adds simulation-only protocol checks.
module shared_vfifo_1r1w
  import shared_vfifo_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4,
  parameter int fifos_p = 3,
  localparam int id_w_lp = safe_clog2(fifos_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  input  logic [id_w_lp-1:0]              enq_id_i,
  input  logic [width_p-1:0]              data_i,
  output logic [fifos_p-1:0]              ready_param_o,
  output logic [fifos_p-1:0]              v_o,
  output logic [fifos_p-1:0][width_p-1:0] data_o,
  input  logic [fifos_p-1:0]              yumi_i
);

  localparam int ptr_w_lp  = safe_clog2(els_p);
  localparam int depth_lp  = fifos_p * els_p;
  localparam int addr_w_lp = addr_width(fifos_p, els_p);

  logic [ptr_w_lp-1:0] wptr   [fifos_p];
  logic [ptr_w_lp-1:0] rptr_n [fifos_p];
  logic [fifos_p-1:0]  full, empty, enq, same;

  logic [fifos_p-1:0][width_p-1:0] bypass_r, head_r, head_n;
  logic [fifos_p-1:0]              bypass_v_r;

  logic                 ram_we, ram_re;
  logic [addr_w_lp-1:0] ram_waddr, ram_raddr;
  logic [id_w_lp-1:0]   rd_id_n, rd_id_r;
  logic                 rd_v_r;
  logic [width_p-1:0]   mem [depth_lp];
  logic [width_p-1:0]   ram_q;

  for (genvar g = 0; g < fifos_p; g++) begin : g_trk
    shared_vfifo_tracker #(.els_p(els_p)) trk (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .enq       (enq[g]),
      .deq       (yumi_i[g]),
      .wptr      (wptr[g]),
      .rptr_n    (rptr_n[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  assign ready_param_o = ~full;
  assign v_o           = ~empty;

  // Enqueue decode, bypass selection and RAM port muxing. Enqueue is
  // one-hot and yumi is onehot0, so at most one FIFO drives each port.
  always_comb begin
    enq       = '0;
    same      = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    rd_id_n   = '0;
    for (int i = 0; i < fifos_p; i++) begin
      enq[i]  = v_i && (enq_id_i == id_w_lp'(i)) && !full[i];
      // The incoming element is the head next cycle: keep it out of the RAM.
      same[i] = enq[i] && (wptr[i] == rptr_n[i]);
      if (enq[i] && !same[i]) begin
        ram_we    = 1'b1;
        ram_waddr = addr_w_lp'(i * els_p) + addr_w_lp'(wptr[i]);
      end
      // Another element remains behind the one leaving: fetch it as new head.
      if (yumi_i[i] && (wptr[i] != rptr_n[i])) begin
        ram_re    = 1'b1;
        ram_raddr = addr_w_lp'(i * els_p) + addr_w_lp'(rptr_n[i]);
        rd_id_n   = id_w_lp'(i);
      end
    end
  end

  // RAM data flows straight through to the head in the cycle it returns,
  // giving bubble-free back-to-back dequeues.
  always_comb begin
    head_n = head_r;
    data_o = '0;
    for (int i = 0; i < fifos_p; i++) begin
      if (rd_v_r && (rd_id_r == id_w_lp'(i))) head_n[i] = ram_q;
      data_o[i] = bypass_v_r[i] ? bypass_r[i] : head_n[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= data_i;
    if (ram_re) ram_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_r     <= 1'b0;
      rd_id_r    <= '0;
      bypass_v_r <= '0;
      bypass_r   <= '0;
      head_r     <= '0;
    end else begin
      rd_v_r <= ram_re;
      if (ram_re) rd_id_r <= rd_id_n;
      head_r <= head_n;
      for (int i = 0; i < fifos_p; i++) begin
        if (same[i]) bypass_r[i] <= data_i;
        // Set dominates clear.
        bypass_v_r[i] <= same[i] ? 1'b1 : (yumi_i[i] ? 1'b0 : bypass_v_r[i]);
      end
    end
  end

`ifdef SHARED_VFIFO_CHECKS_EN
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (v_i && (int'(enq_id_i) < fifos_p) && full[enq_id_i])
        $error("shared_vfifo_1r1w: enqueue to full fifo %0d", enq_id_i);
      if (v_i && (int'(enq_id_i) >= fifos_p))
        $error("shared_vfifo_1r1w: enq_id_i %0d out of range", enq_id_i);
      if ((yumi_i & empty) != '0)
        $error("shared_vfifo_1r1w: yumi_i on empty fifo (%b)", yumi_i);
      if (!$onehot0(yumi_i))
        $error("shared_vfifo_1r1w: yumi_i not onehot0 (%b)", yumi_i);
      if (ram_we && ram_re && (ram_waddr == ram_raddr))
        $error("shared_vfifo_1r1w: same-address ram read/write at %0d", ram_waddr);
    end
  end
`else
`endif

endmodule

// File: tb/tb_shared_vfifo_1r1w.sv
module tb_shared_vfifo_1r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  // DUT A: width 8, els 4, fifos 3
  logic             v_a = 1'b0;
  logic [1:0]       id_a = '0;
  logic [7:0]       d_a = '0;
  logic [2:0]       y_a = '0;
  logic [2:0]       ready_a, vo_a;
  logic [2:0][7:0]  data_a;

  // DUT B: width 4, els 1, fifos 2
  logic             v_b = 1'b0;
  logic [0:0]       id_b = '0;
  logic [3:0]       d_b = '0;
  logic [1:0]       y_b = '0;
  logic [1:0]       ready_b, vo_b;
  logic [1:0][3:0]  data_b;

  shared_vfifo_1r1w #(.width_p(8), .els_p(4), .fifos_p(3)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_a), .enq_id_i(id_a), .data_i(d_a),
    .ready_param_o(ready_a), .v_o(vo_a), .data_o(data_a), .yumi_i(y_a)
  );

  shared_vfifo_1r1w #(.width_p(4), .els_p(1), .fifos_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_b), .enq_id_i(id_b), .data_i(d_b),
    .ready_param_o(ready_b), .v_o(vo_b), .data_o(data_b), .yumi_i(y_b)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model for DUT A: one queue per FIFO.
  logic [7:0] mq [3][$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  always @(negedge reset_n) begin
    for (int i = 0; i < 3; i++) mq[i].delete();
  end

  // Ready is judged on pre-edge occupancy, so a full FIFO rejects an
  // enqueue even when it is dequeued in the same cycle.
  always @(posedge clk) begin
    if (reset_n) begin
      bit acc;
      acc = v_a && (int'(id_a) < 3) && (mq[id_a].size() < 4);
      for (int i = 0; i < 3; i++)
        if (y_a[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (acc) mq[id_a].push_back(d_a);
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vo_a[i] !== (mq[i].size() > 0)) begin
          errors++;
          $display("FAIL cmp_v fifo%0d got %b want %b", i, vo_a[i], mq[i].size() > 0);
        end
        checks++;
        if (ready_a[i] !== (mq[i].size() < 4)) begin
          errors++;
          $display("FAIL cmp_ready fifo%0d got %b want %b", i, ready_a[i], mq[i].size() < 4);
        end
        if (mq[i].size() > 0) begin
          checks++;
          if (data_a[i] !== mq[i][0]) begin
            errors++;
            $display("FAIL cmp_data fifo%0d got 0x%0h want 0x%0h", i, data_a[i], mq[i][0]);
          end
        end
      end
    end
  end

  // Inputs change on the falling edge; outputs have no combinational
  // dependence on inputs, so checks on that same edge are safe.
  task automatic cyc(input logic v, input logic [1:0] id, input logic [7:0] d, input logic [2:0] y);
    v_a = v; id_a = id; d_a = d; y_a = y;
    @(negedge clk);
    v_a = 1'b0; y_a = '0;
  endtask

  task automatic cyc_b(input logic v, input logic id, input logic [3:0] d, input logic [1:0] y);
    v_b = v; id_b = id; d_b = d; y_b = y;
    @(negedge clk);
    v_b = 1'b0; y_b = '0;
  endtask

  task automatic rand_phase(input int n, input int deq_pct);
    for (int k = 0; k < n; k++) begin
      logic [2:0] y;
      int f;
      y = '0;
      if ($urandom_range(0, 99) < deq_pct) begin
        f = $urandom_range(0, 2);
        if (mq[f].size() > 0) y[f] = 1'b1;
      end
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), y);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_v", 32'(vo_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h7);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_b_ready", 32'(ready_b), 32'h3);
    reset_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // single enqueue
    cyc(1'b1, 2'd0, 8'hA5, 3'b000);
    chk("enq_v", 32'(vo_a), 32'h1);
    chk("enq_data0", 32'(data_a[0]), 32'hA5);
    chk("enq_ready", 32'(ready_a), 32'h7);

    // fill FIFO 1, overflow dropped, drain back-to-back
    for (int k = 1; k <= 4; k++) cyc(1'b1, 2'd1, 8'(k), 3'b000);
    chk("full_ready1", 32'(ready_a[1]), 32'h0);
    cyc(1'b1, 2'd1, 8'h05, 3'b000);
    chk("drop_ready1", 32'(ready_a[1]), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data1", 32'(data_a[1]), 32'(k));
      cyc(1'b0, 2'd0, 8'h00, 3'b010);
    end
    chk("drain_v1", 32'(vo_a[1]), 32'h0);

    // same-cycle enq+deq on a one-element FIFO goes through bypass
    cyc(1'b1, 2'd2, 8'h10, 3'b000);
    chk("one_data2", 32'(data_a[2]), 32'h10);
    cyc(1'b1, 2'd2, 8'h11, 3'b100);
    chk("byp_v2", 32'(vo_a[2]), 32'h1);
    chk("byp_data2", 32'(data_a[2]), 32'h11);
    cyc(1'b0, 2'd0, 8'h00, 3'b100);
    chk("byp_empty2", 32'(vo_a[2]), 32'h0);

    // out-of-range id is dropped
    cyc(1'b1, 2'd3, 8'hEE, 3'b000);
    chk("oor_v", 32'(vo_a), 32'h1);

    // interleave: enqueue FIFO 0 while draining FIFO 1
    cyc(1'b1, 2'd1, 8'h20, 3'b000);
    cyc(1'b1, 2'd1, 8'h21, 3'b000);
    cyc(1'b1, 2'd1, 8'h22, 3'b000);
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'd0, 8'(8'h30 + k), 3'b010);
    chk("il_data0", 32'(data_a[0]), 32'hA5);
    chk("il_v", 32'(vo_a), 32'h1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'd0, 8'h00, 3'b001);
    chk("il_head0", 32'(data_a[0]), 32'h32);

    // randomized traffic, then asynchronous reset mid-stream
    rand_phase(1500, 30);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_v", 32'(vo_a), 32'h0);
    chk("async_ready", 32'(ready_a), 32'h7);
    chk("async_data", 32'(data_a), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rand_phase(1500, 90);
    rand_phase(1500, 45);

    // DUT B: single-entry FIFOs never touch the RAM
    cyc_b(1'b1, 1'b1, 4'h7, 2'b00);
    chk("b_ready", 32'(ready_b), 32'h1);
    chk("b_v", 32'(vo_b), 32'h2);
    chk("b_data1", 32'(data_b[1]), 32'h7);
    cyc_b(1'b1, 1'b1, 4'h8, 2'b00);
    chk("b_drop", 32'(data_b[1]), 32'h7);
    cyc_b(1'b1, 1'b0, 4'h3, 2'b10);
    chk("b_v2", 32'(vo_b), 32'h1);
    chk("b_data0", 32'(data_b[0]), 32'h3);
    cyc_b(1'b1, 1'b0, 4'h9, 2'b01);
    chk("b_v3", 32'(vo_b), 32'h0);
    chk("b_ready3", 32'(ready_b), 32'h3);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
